// File: rtl/lmi_iram_cmp_pkg.sv
// Shared LMI symbols: default region-compare geometry for the IRAM address decoder.
package lmi_iram_cmp_pkg;

    localparam int LMI_BASE_LO  = 16;               // region granularity: 64 KiB window
    localparam int LMI_TOP_HI   = LMI_BASE_LO - 1;  // TOP spans the offset field up to BASE
    localparam int LMI_LINE_LSB = 4;                // 16-byte line offset LSB

    // Width of the byte-sliced equality field for a given BASE_LO.
    function automatic int lmi_eq_slices(input int base_lo);
        return (32 - base_lo + 7) / 8;
    endfunction

endpackage

// File: rtl/lmi_iram_cmp.sv
// IRAM region decoder: ADDR hits when its upper bits equal BASE and its line
// offset is at or below TOP. CMP is combinational, CMP_R is its registered copy.
module lmi_iram_cmp
    import lmi_iram_cmp_pkg::*;
#(
    parameter int BASE_LO = LMI_BASE_LO,
    parameter int TOP_HI  = LMI_TOP_HI
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [31:0]                    ADDR,
    input  logic [31:BASE_LO]              BASE,
    input  logic [TOP_HI:LMI_LINE_LSB]     TOP,
    output logic                           CMP,
    output logic                           CMP_R
);

    localparam int BW  = 32 - BASE_LO;
    localparam int OW  = TOP_HI - LMI_LINE_LSB + 1;
    localparam int NSL = lmi_eq_slices(BASE_LO);

    if (TOP_HI != BASE_LO - 1) begin : g_bad_geom
        $error("lmi_iram_cmp: TOP_HI must equal BASE_LO-1");
    end

    logic [BW-1:0]  w_addr_hi;
    logic [BW-1:0]  w_base;
    logic [OW-1:0]  w_off;
    logic [OW-1:0]  w_top;
    logic [NSL-1:0] w_eq_sl;
    logic           w_eq;
    logic           w_le;
    logic           w_unused;
    logic           r_cmp;

    assign w_addr_hi = ADDR[31:BASE_LO];
    assign w_base    = BASE;
    assign w_off     = ADDR[TOP_HI:LMI_LINE_LSB];
    assign w_top     = TOP;
    assign w_unused  = ^ADDR[LMI_LINE_LSB-1:0];

    // Per-byte equality slices; the last slice is narrower when BW is not a multiple of 8.
    for (genvar s = 0; s < NSL; s++) begin : g_eq
        localparam int LO = s * 8;
        localparam int HI = (LO + 7 < BW) ? LO + 7 : BW - 1;
        assign w_eq_sl[s] = (w_addr_hi[HI:LO] == w_base[HI:LO]);
    end

    assign w_eq = &w_eq_sl;

    // MSB-first cascade: the first differing bit decides; later bits cannot override it.
    always_comb begin
        logic w_gt;
        logic w_lt;
        logic w_gt_n;
        w_gt   = 1'b0;
        w_lt   = 1'b0;
        w_gt_n = 1'b0;
        for (int i = OW - 1; i >= 0; i--) begin
            w_gt_n = w_gt | (~w_lt & w_off[i] & ~w_top[i]);
            w_lt   = w_lt | (~w_gt & ~w_off[i] & w_top[i]);
            w_gt   = w_gt_n;
        end
        w_le = ~w_gt;
    end

    assign CMP = w_eq & w_le;

    always_ff @(posedge CLK) begin
        if (RESET) r_cmp <= 1'b0;
        else       r_cmp <= CMP;
    end

    assign CMP_R = r_cmp;

endmodule

// File: tb/tb_lmi_iram_cmp.sv
// Self-checking bench for lmi_iram_cmp: directed boundary cases plus random sweep.
module tb_lmi_iram_cmp;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] ADDR;
    logic [31:16] BASE;
    logic [15:4] TOP;
    logic        CMP;
    logic        CMP_R;

    int n_chk  = 0;
    int n_pass = 0;
    bit q_exp[$];

    always #5 CLK = ~CLK;

    lmi_iram_cmp dut (
        .CLK   (CLK),
        .RESET (RESET),
        .ADDR  (ADDR),
        .BASE  (BASE),
        .TOP   (TOP),
        .CMP   (CMP),
        .CMP_R (CMP_R)
    );

    function automatic bit model(input logic [31:0] a, input logic [15:0] b, input logic [11:0] t);
        return (a[31:16] == b) && (a[15:4] <= t);
    endfunction

    // Drives one vector just after a falling edge so CMP settles well before the next rise.
    task automatic drive(input logic [31:0] a, input logic [15:0] b, input logic [11:0] t);
        @(negedge CLK);
        ADDR = a;
        BASE = b;
        TOP  = t;
        #1;
    endtask

    task automatic test_reset();
        bit e;
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(32'h0800_1234, 16'h0800, 12'hFFF);
            n_chk++;
            if (CMP !== 1'b1) $display("FAIL reset_cmp[%0d] CMP got %b want 1", i, CMP);
            else n_pass++;
            q_exp.push_back(1'b0);
            @(posedge CLK); #1;
            e = q_exp.pop_front();
            n_chk++;
            if (CMP_R !== e) $display("FAIL reset_cmpr[%0d] CMP_R got %b want %b", i, CMP_R, e);
            else n_pass++;
        end
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_chk++;
        if (CMP_R !== 1'b0) $display("FAIL reset_hold CMP_R got %b want 0", CMP_R);
        else n_pass++;
        q_exp.push_back(model(ADDR, BASE, TOP));
        @(posedge CLK); #1;
        e = q_exp.pop_front();
        n_chk++;
        if (CMP_R !== e || CMP_R !== 1'b1) $display("FAIL reset_release CMP_R got %b want 1", CMP_R);
        else n_pass++;
    endtask

    task automatic test_full_window();
        bit e;
        drive(32'h0800_1234, 16'h0800, 12'hFFF);
        n_chk++;
        if (CMP !== 1'b1) $display("FAIL full_window CMP got %b want 1", CMP);
        else n_pass++;
        q_exp.push_back(1'b1);
        @(posedge CLK); #1;
        e = q_exp.pop_front();
        n_chk++;
        if (CMP_R !== e) $display("FAIL full_window_r CMP_R got %b want %b", CMP_R, e);
        else n_pass++;
    endtask

    // Table-driven directed vectors: top edge, base mismatch, minimal window, low-nibble immunity.
    task automatic test_boundaries();
        logic [31:0] a_t[10];
        logic [11:0] t_t[10];
        bit          x_t[10];
        bit e;
        a_t = '{32'h0800_1000, 32'h0800_100F, 32'h0800_1010, 32'h0801_0000, 32'h0000_0000,
                32'h0800_0000, 32'h0800_0010, 32'h0800_FFFF, 32'h0800_000F, 32'h0900_0000};
        t_t = '{12'h100, 12'h100, 12'h100, 12'hFFF, 12'hFFF,
                12'h000, 12'h000, 12'hFFF, 12'h000, 12'hFFF};
        x_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(a_t[i], 16'h0800, t_t[i]);
            n_chk++;
            if (CMP !== x_t[i])
                $display("FAIL boundary[%0d] addr=%h top=%h CMP got %b want %b", i, a_t[i], t_t[i], CMP, x_t[i]);
            else n_pass++;
            q_exp.push_back(x_t[i]);
            @(posedge CLK); #1;
            e = q_exp.pop_front();
            n_chk++;
            if (CMP_R !== e) $display("FAIL boundary_r[%0d] CMP_R got %b want %b", i, CMP_R, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bit e;
        drive(32'h0800_0040, 16'h0800, 12'h010);
        q_exp.push_back(1'b1);
        @(posedge CLK); #1;
        e = q_exp.pop_front();
        n_chk++;
        if (CMP_R !== e) $display("FAIL mid_pre CMP_R got %b want %b", CMP_R, e);
        else n_pass++;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        n_chk++;
        if (CMP !== 1'b1) $display("FAIL mid_cmp CMP got %b want 1", CMP);
        else n_pass++;
        q_exp.push_back(1'b0);
        @(posedge CLK); #1;
        e = q_exp.pop_front();
        n_chk++;
        if (CMP_R !== e) $display("FAIL mid_clear CMP_R got %b want %b", CMP_R, e);
        else n_pass++;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [15:0] b;
        logic [11:0] t;
        bit m, e;
        int n_bad = 0;
        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            t = 12'($urandom);
            b = ($urandom_range(0, 3) != 0) ? a[31:16] : 16'($urandom);
            if ($urandom_range(0, 7) == 0) b = a[31:16] ^ (16'h1 << $urandom_range(0, 15));
            drive(a, b, t);
            m = model(a, b, t);
            n_chk++;
            if (CMP !== m) begin
                if (n_bad < 10) $display("FAIL random[%0d] a=%h b=%h t=%h CMP got %b want %b", i, a, b, t, CMP, m);
                n_bad++;
            end else n_pass++;
            q_exp.push_back(m);
            @(posedge CLK); #1;
            e = q_exp.pop_front();
            n_chk++;
            if (CMP_R !== e) begin
                if (n_bad < 10) $display("FAIL random_r[%0d] CMP_R got %b want %b", i, CMP_R, e);
                n_bad++;
            end else n_pass++;
        end
    endtask

    initial begin
        RESET = 1'b1;
        ADDR  = '0;
        BASE  = '0;
        TOP   = '0;
        test_reset();
        test_full_window();
        test_boundaries();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lmi_iram_cmp.md
LMI_IRAM_CMP -- requirements
Module: lmi_iram_cmp

Interface
REQ-001 Parameter BASE_LO, default 16: lowest BASE bit and lowest address bit of the region-select compare.
REQ-002 Parameter TOP_HI, default 15: highest TOP bit; SHALL equal BASE_LO-1, with elaboration error otherwise.
REQ-003 Design uses one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  rising-edge clock for the registered output.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 ADDR  input  32  physical address to test; bits 3:0 ignored.
REQ-007 BASE  input  [31:BASE_LO]  region base; upper address bits that must match exactly.
REQ-008 TOP  input  [TOP_HI:4]  highest 16-byte line offset inside the region, inclusive.
REQ-009 CMP  output  1  combinational in-range flag.
REQ-010 CMP_R  output  1  CMP registered one cycle.

Function
REQ-011 CMP SHALL be 1 iff ADDR[31:BASE_LO] == BASE and ADDR[TOP_HI:4] <= TOP (unsigned); otherwise 0.
REQ-012 CMP SHALL be purely combinational, zero-cycle latency; no internal state on the CMP path.
REQ-013 ADDR[3:0] SHALL NOT affect CMP.
REQ-014 Boundary: offset == TOP SHALL hit; offset == TOP+1 SHALL miss.
REQ-015 Boundary: TOP == 0 SHALL hit only offset 0, which is one 16-byte line.
REQ-016 Boundary: TOP all-ones SHALL hit the entire 2^BASE_LO-byte window.
REQ-017 A single-bit BASE mismatch SHALL force CMP=0 regardless of offset.
REQ-018 CMP_R SHALL capture CMP on every rising CLK edge when RESET=0.
REQ-019 X on any input bit used in the compare SHALL be allowed to propagate to CMP; no X masking.

Reset
REQ-020 With RESET=1 at a rising CLK edge, CMP_R SHALL become 0.
REQ-021 CMP SHALL be unaffected by RESET and SHALL keep tracking its inputs during reset.
REQ-022 In the first edge after RESET falls, CMP_R SHALL load the current CMP.
REQ-023 Asserting reset mid-operation SHALL clear CMP_R at the next edge.

Structure
REQ-024 Default BASE_LO/TOP_HI and the 16-byte line-offset LSB (4) SHALL live in the shared LMI symbols package.
REQ-025 Implementation SHALL consist of:
- an equality compare, split into per-byte equality slices;
- a magnitude compare, built as a MSB-first cascaded less-or-equal tree;
- an output register.
REQ-026 No sub-module is needed; the block is a leaf.

Verification (BASE=0x0800, TOP width 12)
REQ-027 Full window: TOP=0xFFF, ADDR=0x0800_1234 -> CMP=1; one cycle later CMP_R=1.
REQ-028 Top edge: TOP=0x100.
- ADDR=0x0800_1000 -> CMP=1.
- ADDR=0x0800_100F -> CMP=1.
- ADDR=0x0800_1010 -> CMP=0.
REQ-029 Base mismatch: TOP=0xFFF.
- ADDR=0x0801_0000 -> CMP=0.
- ADDR=0x0000_0000 -> CMP=0.
REQ-030 Minimal window: TOP=0x000.
- ADDR=0x0800_0000 -> CMP=1.
- ADDR=0x0800_0010 -> CMP=0.
REQ-031 Reset: hold RESET=1 with a hitting ADDR -> CMP=1, CMP_R=0. Deassert RESET -> CMP_R=1 after one edge.
REQ-032 Random: 10k random ADDR/BASE/TOP triples; CMP SHALL match the REQ-011 model, and CMP_R SHALL equal the previous cycle's CMP.
